mmu_loader: RTL and testbench
=============================

Name: mmu_loader

Overview:
Host-facing load/sequence controller directly upstream of the MMU feeder. Accepts operand bytes from the host over a valid/ready byte stream and holds them in four weight and four input registers that drive the feeder's memory interface. It then drives the feeder's en/mmu_cycle through one compute pass and steps output_sel through the four results with an output handshake. Weight reuse lets a new input tile be run without reloading weights.

Parameters:
COMPUTE_CYCLES, 6, number of mmu_cycle steps (0..COMPUTE_CYCLES-1) per pass; legal range 1..7.
READ_CYCLE, 7, mmu_cycle value held during readout; must be ≥ COMPUTE_CYCLES so the feeder presents zeros.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
host_valid  input  1  host byte strobe
host_data  input  8  host operand byte
keep_weights  input  1  sampled with the first byte of a load; 1 = reuse stored weights
host_ready  output  1  loader accepts a byte this cycle
out_ready  input  1  host consumes the current result byte
out_valid  output  1  result byte on the feeder's host_outdata is valid
weight0..weight3  output  8 each  stored weights to the feeder
input0..input3  output  8 each  stored inputs to the feeder
en  output  1  feeder enable
mmu_cycle  output  3  feeder cycle index
output_sel  output  2  feeder result select
busy  output  1  high in COMPUTE or READOUT

Behaviour:
- Reset: state LOAD, idx=0, weights_ok=0, all weight/input regs 0, en=0, mmu_cycle=0, output_sel=0, out_valid=0, busy=0. Asynchronous reset mid-operation aborts immediately. Registers clear to 0. No partial result is read out.
- All outputs are registered except host_ready, which is high exactly when state==LOAD.
- Byte accept = host_valid && host_ready, one byte per clk.
- LOAD state, 4-bit idx:
  - Order is weight0, weight1, weight2, weight3, input0, input1, input2, input3. Byte at idx k writes weight k for k<4 and input (k-4) for k≥4.
  - First byte (idx==0) with keep_weights=1 and weights_ok=1: byte is written to input0, idx becomes 5, weights are untouched.
  - keep_weights=1 with weights_ok=0 is ignored; the load is a normal 8-byte load.
  - keep_weights is ignored on all bytes other than the first.
  - weights_ok is set when weight3 is written. It is cleared only by reset.
  - Accepting input3 moves to COMPUTE on the next edge with en=1, mmu_cycle=0 and idx=0.
- COMPUTE: en=1. mmu_cycle increments once per clk. The cycle after mmu_cycle==COMPUTE_CYCLES-1, move to READOUT with mmu_cycle=READ_CYCLE, output_sel=0 and out_valid=1. COMPUTE lasts exactly COMPUTE_CYCLES cycles. The host cannot stall it. host_valid is ignored.
- READOUT: en=1 and mmu_cycle=READ_CYCLE are held so the feeder keeps its accumulators and passes results through.
  - When out_valid && out_ready, output_sel increments.
  - On the handshake at output_sel==3: out_valid=0, en=0 (feeder clears the array), mmu_cycle=0, output_sel=0, state=LOAD.
  - out_ready low holds output_sel indefinitely.
- Latency: 8 accepted bytes (or 4 with reuse), then COMPUTE_CYCLES cycles, then ≥4 readout cycles. The first host_ready after the last readout handshake is on the next cycle.
- Weight/input registers change only on accepted writes in LOAD. They are stable throughout COMPUTE and READOUT.
- mmu_cycle never wraps. Width rules: all data is 8-bit, with no arithmetic on data.

Test Plan:
- Reset then stream weights 1,2,3,4 and inputs 5,6,7,8 back-to-back → weight0..3=1..4 and input0..3=5..8. en rises the cycle after the 8th byte. mmu_cycle reads 0,1,2,3,4,5 and is then held at 7.
- READOUT with out_ready=1 every cycle → out_valid high for 4 cycles, output_sel 0,1,2,3. Then en=0, host_ready=1 and state LOAD.
- READOUT with out_ready toggled 1,0,0,1,1,0,1 → output_sel advances only on the high cycles: 0→1, then 1,1, then →2→3, hold, then exit.
- After the first pass, keep_weights=1 with bytes 9,10,11,12 → weights still 1..4, inputs 9..12, and COMPUTE starts after the 4th byte. keep_weights=1 straight after reset → 8-byte load required.
- host_valid held high during COMPUTE and READOUT with data 0xFF → no register changes and host_ready=0 throughout.
- Assert rst at mmu_cycle==3 → all outputs 0 asynchronously. A subsequent keep_weights=1 load requires all 8 bytes (weights_ok cleared).

Source files
------------

// File: rtl/mmu_loader.sv
// mmu_loader: host-facing operand loader and pass sequencer for the MMU feeder.
// Collects four weight and four input bytes from the host, runs one compute
// pass by stepping the feeder's mmu_cycle, then walks output_sel across the
// four results under an output handshake. Weights can be reused so a new
// input tile needs only four bytes.
//
// Handshakes: a host byte is taken on a clk edge where host_valid && host_ready;
// a result is consumed on a clk edge where out_valid && out_ready. Neither
// valid depends combinationally on the matching ready.
module mmu_loader #(
  parameter int COMPUTE_CYCLES = 6,
  parameter int READ_CYCLE     = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_valid,
  input  logic [7:0] host_data,
  input  logic       keep_weights,
  output logic       host_ready,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] weight0,
  output logic [7:0] weight1,
  output logic [7:0] weight2,
  output logic [7:0] weight3,
  output logic [7:0] input0,
  output logic [7:0] input1,
  output logic [7:0] input2,
  output logic [7:0] input3,
  output logic       en,
  output logic [2:0] mmu_cycle,
  output logic [1:0] output_sel,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_READOUT = 2'd2
  } state_t;

  localparam logic [2:0] LAST_CYC = 3'(COMPUTE_CYCLES - 1);
  localparam logic [2:0] RD_CYC   = 3'(READ_CYCLE);

  state_t     state, state_nx;
  logic [3:0] idx, idx_nx;
  logic       weights_ok, weights_ok_nx;
  logic [7:0] w_q [4];
  logic [7:0] w_nx [4];
  logic [7:0] x_q [4];
  logic [7:0] x_nx [4];
  logic       en_nx;
  logic [2:0] cyc_nx;
  logic [1:0] sel_nx;
  logic       out_valid_nx;
  logic       busy_nx;
  logic       accept;

  assign host_ready = (state == S_LOAD);
  assign accept     = host_valid && host_ready;

  assign weight0 = w_q[0];
  assign weight1 = w_q[1];
  assign weight2 = w_q[2];
  assign weight3 = w_q[3];
  assign input0  = x_q[0];
  assign input1  = x_q[1];
  assign input2  = x_q[2];
  assign input3  = x_q[3];

  // Next-state and next-output logic for the load / compute / readout sequence.
  always_comb begin
    state_nx      = state;
    idx_nx        = idx;
    weights_ok_nx = weights_ok;
    w_nx          = w_q;
    x_nx          = x_q;
    en_nx         = en;
    cyc_nx        = mmu_cycle;
    sel_nx        = output_sel;
    out_valid_nx  = out_valid;
    busy_nx       = busy;
    case (state)
      S_LOAD: begin
        if (accept) begin
          if (idx == 4'd0 && keep_weights && weights_ok) begin
            // Weight reuse: first byte of the load is already input0.
            x_nx[0] = host_data;
            idx_nx  = 4'd5;
          end else if (idx < 4'd4) begin
            w_nx[idx[1:0]] = host_data;
            if (idx == 4'd3) weights_ok_nx = 1'b1;
            idx_nx = idx + 4'd1;
          end else begin
            x_nx[idx[1:0]] = host_data;
            if (idx == 4'd7) begin
              state_nx = S_COMPUTE;
              en_nx    = 1'b1;
              cyc_nx   = 3'd0;
              idx_nx   = 4'd0;
              busy_nx  = 1'b1;
            end else begin
              idx_nx = idx + 4'd1;
            end
          end
        end
      end
      S_COMPUTE: begin
        if (mmu_cycle == LAST_CYC) begin
          state_nx     = S_READOUT;
          cyc_nx       = RD_CYC;
          sel_nx       = 2'd0;
          out_valid_nx = 1'b1;
        end else begin
          cyc_nx = mmu_cycle + 3'd1;
        end
      end
      S_READOUT: begin
        if (out_valid && out_ready) begin
          if (output_sel == 2'd3) begin
            // Dropping en makes the feeder clear its array for the next pass.
            state_nx     = S_LOAD;
            out_valid_nx = 1'b0;
            en_nx        = 1'b0;
            cyc_nx       = 3'd0;
            sel_nx       = 2'd0;
            busy_nx      = 1'b0;
          end else begin
            sel_nx = output_sel + 2'd1;
          end
        end
      end
      default: begin
        state_nx = S_LOAD;
      end
    endcase
  end

  // State and output registers; reset aborts any pass in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_LOAD;
      idx        <= 4'd0;
      weights_ok <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        w_q[i] <= 8'd0;
        x_q[i] <= 8'd0;
      end
      en         <= 1'b0;
      mmu_cycle  <= 3'd0;
      output_sel <= 2'd0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      weights_ok <= weights_ok_nx;
      for (int i = 0; i < 4; i++) begin
        w_q[i] <= w_nx[i];
        x_q[i] <= x_nx[i];
      end
      en         <= en_nx;
      mmu_cycle  <= cyc_nx;
      output_sel <= sel_nx;
      out_valid  <= out_valid_nx;
      busy       <= busy_nx;
    end
  end

endmodule

// File: tb/tb_mmu_loader.sv
// tb_mmu_loader: randomized bench for mmu_loader with a scoreboard of
// expected readout handshakes and a register-level reference model.
module tb_mmu_loader;

  localparam int CC = 6;
  localparam int RC = 7;

  logic       clk;
  logic       rst;
  logic       host_valid;
  logic [7:0] host_data;
  logic       keep_weights;
  logic       host_ready;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] weight0, weight1, weight2, weight3;
  logic [7:0] input0, input1, input2, input3;
  logic       en;
  logic [2:0] mmu_cycle;
  logic [1:0] output_sel;
  logic       busy;

  mmu_loader #(.COMPUTE_CYCLES(CC), .READ_CYCLE(RC)) dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_data(host_data), .keep_weights(keep_weights),
    .host_ready(host_ready), .out_ready(out_ready), .out_valid(out_valid),
    .weight0(weight0), .weight1(weight1), .weight2(weight2), .weight3(weight3),
    .input0(input0), .input1(input1), .input2(input2), .input3(input3),
    .en(en), .mmu_cycle(mmu_cycle), .output_sel(output_sel), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking counters and scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [65:0] exp_q[$];

  // reference model: stored operands and the weights-valid flag
  logic [7:0] mw [4];
  logic [7:0] mx [4];
  bit         mok;
  logic [7:0] lb [8];

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] dut_regs();
    return {weight0, weight1, weight2, weight3, input0, input1, input2, input3};
  endfunction

  function automatic logic [63:0] model_regs();
    return {mw[0], mw[1], mw[2], mw[3], mx[0], mx[1], mx[2], mx[3]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mw[i] = 8'd0;
      mx[i] = 8'd0;
    end
    mok = 1'b0;
  endtask

  task automatic check_idle(input string name);
    chk({name, "_host_ready"}, host_ready, 1);
    chk({name, "_en"}, en, 0);
    chk({name, "_mmu_cycle"}, mmu_cycle, 0);
    chk({name, "_output_sel"}, output_sel, 0);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  // monitor: every result handshake must match the next scoreboard entry
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        logic [65:0] e;
        e = exp_q.pop_front();
        chk("result_sel_regs", {output_sel, dut_regs()}, e);
        chk("result_mmu_cycle", {en, mmu_cycle}, {1'b1, 3'(RC)});
      end
    end
  end

  // driver: present one byte at a negedge and hold it until accepted
  task automatic send_byte(input logic [7:0] d, input bit k);
    int t;
    t = 0;
    @(negedge clk);
    host_valid   = 1'b1;
    host_data    = d;
    keep_weights = k;
    while (!host_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("byte_accept", host_ready, 1);
    @(posedge clk);
  endtask

  // one load + compute + readout pass; abort_at >= 0 pulses reset at that mmu_cycle
  task automatic run_pass(input bit keep, input int ro_mode, input bit hold, input int abort_at);
    bit reuse;
    int n;
    int k;
    bit prev_last;
    bit pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    reuse = keep && mok;
    n = reuse ? 4 : 8;
    for (int i = 0; i < n; i++) begin
      int slot;
      slot = reuse ? i + 4 : i;
      send_byte(lb[i], (i == 0) ? keep : 1'($urandom_range(0, 1)));
      if (slot < 4) begin
        mw[slot] = lb[i];
        if (slot == 3) mok = 1'b1;
      end else begin
        mx[slot - 4] = lb[i];
      end
    end
    @(negedge clk);
    host_valid   = hold;
    host_data    = 8'hFF;
    keep_weights = 1'($urandom_range(0, 1));
    for (int c = 0; c < CC; c++) begin
      chk("compute_mmu_cycle", mmu_cycle, c);
      chk("compute_flags", {en, busy, host_ready, out_valid}, 4'b1100);
      chk("compute_regs", dut_regs(), model_regs());
      if (c == abort_at) begin
        #1 rst = 1'b1;
        #1;
        host_valid = 1'b0;
        out_ready  = 1'b0;
        model_clear();
        check_idle("abort");
        chk("abort_regs", dut_regs(), 0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("readout_entry", {en, mmu_cycle, output_sel, out_valid}, {1'b1, 3'(RC), 2'd0, 1'b1});
    for (int s = 0; s < 4; s++) exp_q.push_back({2'(s), model_regs()});
    k = 0;
    prev_last = 1'b0;
    while (k < 200 && !host_ready) begin
      case (ro_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k < 7) ? pat[k] : 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      chk("readout_flags", {busy, host_ready, en}, 3'b101);
      prev_last = out_ready && out_valid && (output_sel == 2'd3);
      @(negedge clk);
      k++;
    end
    host_valid = 1'b0;
    out_ready  = 1'b0;
    chk("exit_after_last_handshake", prev_last, 1);
    check_idle("after_readout");
    chk("after_readout_regs", dut_regs(), model_regs());
  endtask

  task automatic rand_bytes();
    for (int i = 0; i < 8; i++) lb[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    rst          = 1'b1;
    host_valid   = 1'b0;
    host_data    = 8'd0;
    keep_weights = 1'b0;
    out_ready    = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check_idle("in_reset");
    chk("in_reset_regs", dut_regs(), 0);
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset");

    // directed: plain load 1..8, continuous readout
    for (int i = 0; i < 8; i++) lb[i] = 8'(i + 1);
    run_pass(1'b0, 0, 1'b0, -1);
    // directed: reuse weights with 9..12, toggled out_ready, host_valid held high
    for (int i = 0; i < 4; i++) lb[i] = 8'(i + 9);
    run_pass(1'b1, 1, 1'b1, -1);

    // random passes
    for (int p = 0; p < 6; p++) begin
      rand_bytes();
      run_pass(1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)), -1);
    end

    // reset at mmu_cycle 3, then keep_weights must still force a full load
    rand_bytes();
    run_pass(1'b0, 2, 1'b1, 3);
    rand_bytes();
    run_pass(1'b1, 2, 1'b0, -1);
    rand_bytes();
    run_pass(1'b1, 1, 1'b1, -1);

    chk("scoreboard_drained", 66'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
